// File: rtl/idac_cal.sv
// Two-stage IDAC calibration: 8-bit successive-approximation search on the coarse
// code, then a linear upward search on the fine code until the comparator trips.
module idac_cal #(
    parameter int SETTLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       cmp,
    output logic [7:0] ib,
    output logic [7:0] ibf,
    output logic       busy,
    output logic       done,
    output logic       sat
);

    typedef enum logic [2:0] {
        IDLE,
        COARSE_SETTLE,
        COARSE_SAMPLE,
        FINE_SETTLE,
        FINE_SAMPLE,
        DONE
    } state_t;

    localparam int            CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

    generate
        if (SYNC_STAGES < 1 || SETTLE_CYCLES < SYNC_STAGES + 1) begin : g_bad_params
            $error("idac_cal: SETTLE_CYCLES must be >= SYNC_STAGES+1 and SYNC_STAGES >= 1");
        end
    endgenerate

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [2:0]             idx;
    logic [SYNC_STAGES-1:0] sync;
    logic                   cmp_s;

    // The settle time must cover the synchronizer latency so cmp_s reflects the current code.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= '0;
        else       sync <= SYNC_STAGES'({sync, cmp});
    end

    assign cmp_s = sync[SYNC_STAGES-1];

    // NOTE: all state and outputs use non-blocking assignments so every register updates
    // from the same pre-edge values; blocking here would make outputs order-dependent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            ib    <= 8'h7F;
            ibf   <= 8'h00;
            busy  <= 1'b0;
            done  <= 1'b0;
            sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ib    <= 8'h80;
                        ibf   <= 8'h00;
                        idx   <= 3'd7;
                        cnt   <= CNT_LOAD;
                        busy  <= 1'b1;
                        sat   <= 1'b0;
                        state <= COARSE_SETTLE;
                    end
                end

                COARSE_SETTLE: begin
                    if (cnt == '0) state <= COARSE_SAMPLE;
                    else           cnt   <= cnt - 1'b1;
                end

                COARSE_SAMPLE: begin
                    if (cmp_s) ib[idx] <= 1'b0;
                    cnt <= CNT_LOAD;
                    if (idx == 3'd0) begin
                        ibf   <= 8'h00;
                        state <= FINE_SETTLE;
                    end else begin
                        ib[idx - 3'd1] <= 1'b1;
                        idx            <= idx - 3'd1;
                        state          <= COARSE_SETTLE;
                    end
                end

                FINE_SETTLE: begin
                    if (cnt == '0) state <= FINE_SAMPLE;
                    else           cnt   <= cnt - 1'b1;
                end

                FINE_SAMPLE: begin
                    if (cmp_s || ibf == 8'hFF) begin
                        // Saturation only when the top code still did not trip the comparator.
                        sat   <= ~cmp_s;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        ibf   <= ibf + 8'd1;
                        cnt   <= CNT_LOAD;
                        state <= FINE_SETTLE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_idac_cal.sv
// Bench for idac_cal: comparator modelled as (ib*16+ibf >= k); results checked against
// hand-derived vectors and an arithmetic model of the two-stage search.
module tb_idac_cal;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       cmp;
    logic [7:0] ib;
    logic [7:0] ibf;
    logic       busy;
    logic       done;
    logic       sat;
    int         k;

    int checks = 0;
    int errors = 0;

    localparam int MAX_CYC = 6000;

    idac_cal #(.SETTLE_CYCLES(16), .SYNC_STAGES(2)) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .cmp  (cmp),
        .ib   (ib),
        .ibf  (ibf),
        .busy (busy),
        .done (done),
        .sat  (sat)
    );

    always #50 clk = ~clk;

    assign cmp = (int'(ib) * 16 + int'(ibf) >= k);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected outcome from the search rules: the coarse SAR settles on the largest code
    // whose current is below k, then the fine code counts up to the first trip.
    function automatic void model(input int kk, output logic [7:0] e_ib, output logic [7:0] e_ibf,
                                  output logic e_sat, output int e_cyc);
        int c, f;
        c = (kk <= 0) ? 0 : ((kk + 15) / 16 - 1);
        if (c > 255) c = 255;
        f = kk - c * 16;
        if (f < 0) f = 0;
        e_sat = (f > 255);
        if (f > 255) f = 255;
        e_ib  = 8'(c);
        e_ibf = 8'(f);
        e_cyc = 8 * 17 + (f + 1) * 17 + 1;
    endfunction

    // Called right after a negedge. cyc is the clock period in which done is seen,
    // counting the period that follows the start edge as 1.
    task automatic run_cal(input int kk, output int cyc, output bit busy_ok,
                           output bit coarse_ok, output bit pulse_ok);
        k = kk;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        busy_ok = 1'b1;
        coarse_ok = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (!done && !busy) busy_ok = 1'b0;
            if (done && busy) busy_ok = 1'b0;
            if (cyc <= 136 && ibf !== 8'h00) coarse_ok = 1'b0;
        end while (!done && cyc < MAX_CYC);
        @(negedge clk);
        pulse_ok = !done && !busy;
    endtask

    typedef struct {
        int         k;
        logic [7:0] ib;
        logic [7:0] ibf;
        logic       sat;
        int         cyc;
    } vec_t;

    initial begin
        vec_t       vecs[6];
        int         cyc, dones, done_cyc;
        bit         busy_ok, coarse_ok, pulse_ok;
        logic [7:0] e_ib, e_ibf;
        logic       e_sat;
        int         e_cyc, rk;

        vecs[0] = '{1447, 8'h5A, 8'h07, 1'b0, 273};
        vecs[1] = '{0,    8'h00, 8'h00, 1'b0, 154};
        vecs[2] = '{8192, 8'hFF, 8'hFF, 1'b1, 4489};
        vecs[3] = '{16,   8'h00, 8'h10, 1'b0, 426};
        vecs[4] = '{4095, 8'hFF, 8'h0F, 1'b0, 409};
        vecs[5] = '{4336, 8'hFF, 8'hFF, 1'b1, 4489};

        reset = 1'b1;
        start = 1'b0;
        k     = 1447;
        repeat (3) @(negedge clk);
        check("reset_ib",   32'(ib),   32'h7F);
        check("reset_ibf",  32'(ibf),  32'h00);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_sat",  32'(sat),  32'h0);

        // Start raised together with reset release: must be taken on the very next edge.
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_cal(vecs[i].k, cyc, busy_ok, coarse_ok, pulse_ok);
            check($sformatf("vec%0d_ib", i),     32'(ib),  32'(vecs[i].ib));
            check($sformatf("vec%0d_ibf", i),    32'(ibf), 32'(vecs[i].ibf));
            check($sformatf("vec%0d_sat", i),    32'(sat), 32'(vecs[i].sat));
            check($sformatf("vec%0d_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
            check($sformatf("vec%0d_busy", i),   32'(busy_ok), 32'h1);
            check($sformatf("vec%0d_coarse_ibf", i), 32'(coarse_ok), 32'h1);
            check($sformatf("vec%0d_done_pulse", i), 32'(pulse_ok), 32'h1);
        end

        // Extra start pulses during the search and in the DONE cycle are ignored.
        k = 1447;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dones = 0;
        done_cyc = 0;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                if (done_cyc == 0) done_cyc = c;
            end
            start = (c == 40 || c == 150 || c == 272 || c == 273);
        end
        start = 1'b0;
        check("ignore_done_count", 32'(dones),    32'd1);
        check("ignore_done_cycle", 32'(done_cyc), 32'd273);
        check("ignore_ib",         32'(ib),       32'h5A);
        check("ignore_ibf",        32'(ibf),      32'h07);
        check("ignore_busy",       32'(busy),     32'h0);

        // Reset during coarse trial 4 aborts at once; a new run then completes normally.
        @(negedge clk);
        k = 1447;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (60) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_ib",   32'(ib),   32'h7F);
        check("abort_ibf",  32'(ibf),  32'h00);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_done", 32'(done), 32'h0);
        check("abort_sat",  32'(sat),  32'h0);
        @(negedge clk);
        reset = 1'b0;
        run_cal(1447, cyc, busy_ok, coarse_ok, pulse_ok);
        check("after_abort_ib",     32'(ib),  32'h5A);
        check("after_abort_ibf",    32'(ibf), 32'h07);
        check("after_abort_sat",    32'(sat), 32'h0);
        check("after_abort_cycles", 32'(cyc), 32'd273);

        // Randomized comparator thresholds against the arithmetic model.
        for (int i = 0; i < 16; i++) begin
            rk = (i % 4 == 3) ? int'($urandom_range(4335, 4000)) : int'($urandom_range(4000, 0));
            if (i % 4 == 3) rk = 4080 + int'($urandom_range(40, 0));
            model(rk, e_ib, e_ibf, e_sat, e_cyc);
            run_cal(rk, cyc, busy_ok, coarse_ok, pulse_ok);
            check($sformatf("rand%0d_k%0d_ib", i, rk),     32'(ib),  32'(e_ib));
            check($sformatf("rand%0d_k%0d_ibf", i, rk),    32'(ibf), 32'(e_ibf));
            check($sformatf("rand%0d_k%0d_sat", i, rk),    32'(sat), 32'(e_sat));
            check($sformatf("rand%0d_k%0d_cycles", i, rk), 32'(cyc), 32'(e_cyc));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/idac_cal.md
IDAC_CAL -- requirements
Module: idac_cal

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: clocks the DAC output settles before each comparator sample (1.6 us at 10 MHz).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flops in the comparator synchronizer.
REQ-003 SHALL have port clk, input, 1: clock, 10 MHz nominal.
REQ-004 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1: request a calibration; sampled only in IDLE.
REQ-006 SHALL have port cmp, input, 1: analog comparator result, asynchronous; 1 means DAC current is at or above the reference.
REQ-007 SHALL have port ib, output, 8: coarse IDAC code.
REQ-008 SHALL have port ibf, output, 8: fine IDAC code.
REQ-009 SHALL have port busy, output, 1: high from the start accept until the end of calibration.
REQ-010 SHALL have port done, output, 1: single-cycle pulse when a calibration completes.
REQ-011 SHALL have port sat, output, 1: fine search ended at 8'hFF without a comparator trip; held until the next start.

Function
REQ-012 SHALL pass cmp through SYNC_STAGES flops (cmp_s) before any use; raw cmp SHALL feed nothing else.
REQ-013 SHALL implement FSM states IDLE, COARSE_SETTLE, COARSE_SAMPLE, FINE_SETTLE, FINE_SAMPLE, DONE.
REQ-014 IDLE with start=1 at a clock edge SHALL load ib=8'h80, ibf=8'h00, bit index 7, busy=1, sat=0, and enter COARSE_SETTLE.
REQ-015 Each SETTLE state SHALL last exactly SETTLE_CYCLES clocks (down-counter), then move to its SAMPLE state for one clock; one trial = SETTLE_CYCLES+1 clocks.
REQ-016 COARSE_SAMPLE SHALL clear bit[idx] of ib if cmp_s=1, keep it if cmp_s=0, then set bit[idx-1] and return to COARSE_SETTLE; at idx=0 it SHALL instead enter FINE_SETTLE with ibf=8'h00.
REQ-017 Coarse search SHALL take exactly 8 trials; ibf SHALL stay 8'h00 throughout.
REQ-018 FINE_SAMPLE SHALL enter DONE if cmp_s=1 (ibf held); if cmp_s=0 and ibf=8'hFF, it SHALL set sat=1 and enter DONE; otherwise it SHALL set ibf=ibf+1 and return to FINE_SETTLE.
REQ-019 ibf SHALL never wrap from 8'hFF to 8'h00.
REQ-020 DONE SHALL last one clock with done=1 and busy=0, then return to IDLE; ib and ibf SHALL hold the result until the next start.
REQ-021 start SHALL be ignored in every state except IDLE, including the DONE cycle.
REQ-022 ib and ibf SHALL change only on FSM transitions listed above; they SHALL be registered outputs, glitch-free.
REQ-023 SETTLE_CYCLES SHALL be >= SYNC_STAGES+1; elaboration SHALL fail otherwise.

Reset
REQ-024 While reset=1, outputs SHALL be ib=8'h7F, ibf=8'h00, busy=0, done=0, sat=0; the FSM SHALL be in IDLE; the counter and synchronizer SHALL be cleared.
REQ-025 Reset asserted mid-calibration SHALL abort immediately to the values in REQ-024, with no done pulse.
REQ-026 The first start SHALL be accepted on the first clock edge after reset deasserts.

Verification
REQ-027 Bench comparator model cmp = (ib*16+ibf >= K), with SETTLE_CYCLES=16.
REQ-028 K=1447, pulse start -> ib=8'h5A, ibf=8'h07, sat=0; done exactly 8*17+8*17+1 clocks after the start edge.
REQ-029 K=0 (cmp always 1) -> ib=8'h00, ibf=8'h00, sat=0, after 8 coarse trials and 1 fine trial.
REQ-030 K=8192 (cmp never 1) -> ib=8'hFF, ibf=8'hFF, sat=1, after 8 coarse trials and 256 fine trials.
REQ-031 Start pulses while busy and in the DONE cycle -> ignored; exactly one done pulse; the result is unchanged.
REQ-032 Assert reset during coarse trial 4 -> ib=8'h7F, ibf=8'h00, busy=0, done=0 immediately; a following start with K=1447 gives the result of REQ-028.
